// File: rtl/collision_pkg.sv
// Shared types and helpers for the collision event generator.
// Holds the invulnerability state type and default sizing.
package collision_pkg;

    typedef enum logic {ARMED, INVUL} invul_state_t;

    localparam int NUM_BALLS_DEF    = 4;
    localparam int INVUL_FRAMES_DEF = 60;
    localparam int MAX_BALLS        = 32;

    // Isolate the lowest set bit; zero input yields zero.
    function automatic logic [MAX_BALLS-1:0] lowest_onehot(
        input logic [MAX_BALLS-1:0] v
    );
        return v & (~v + MAX_BALLS'(1));
    endfunction

endpackage

// File: rtl/collision_event_generator_invul_timer.sv
// Player invulnerability window after a reported player-ball hit.
// Advances once per enabled frame tick; counter saturates at zero.
module invul_timer
    import collision_pkg::*;
#(
    parameter int INVUL_FRAMES = INVUL_FRAMES_DEF,
    parameter int INVUL_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic hit,
    output logic invulnerable,
    output logic suppress
);

    invul_state_t       state, state_n;
    logic [INVUL_W-1:0] cnt, cnt_n;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARMED;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Arm on a hit, count frames down, re-arm when the window ends.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (tick) begin
            unique case (state)
                ARMED: begin
                    if (hit) begin
                        state_n = INVUL;
                        cnt_n   = INVUL_W'(INVUL_FRAMES);
                    end
                end
                INVUL: begin
                    if (cnt <= INVUL_W'(1)) begin
                        state_n = ARMED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - INVUL_W'(1);
                    end
                end
                default: begin
                    state_n = ARMED;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign invulnerable = (state == INVUL);
    assign suppress     = (state == INVUL);

    a_frames_nonzero: assert property (
        @(posedge clk) INVUL_FRAMES != 0
    ) else $error("INVUL_FRAMES must be nonzero");

    a_width_fits: assert property (
        @(posedge clk) (64'd1 << INVUL_W) > 64'(INVUL_FRAMES)
    ) else $error("INVUL_W too narrow for INVUL_FRAMES");

endmodule

// File: rtl/collision_event_generator.sv
// Per-frame collision flags from drawing-request overlaps.
// Publishes one-cycle pulses at each frame strobe, then clears.
module collision_event_generator
    import collision_pkg::*;
#(
    parameter int NUM_BALLS    = NUM_BALLS_DEF,
    parameter int INVUL_FRAMES = INVUL_FRAMES_DEF,
    parameter int INVUL_W      = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 enable,
    input  logic                 playerDR,
    input  logic                 ropeDR,
    input  logic                 ropeActive,
    input  logic                 presentDR,
    input  logic [NUM_BALLS-1:0] ballDR,
    output logic [NUM_BALLS-1:0] col_player_ball,
    output logic [NUM_BALLS-1:0] col_rope_ball,
    output logic                 col_present,
    output logic                 invulnerable
);

    logic [NUM_BALLS-1:0] pb_now, rb_now;
    logic                 pp_now;
    logic [NUM_BALLS-1:0] pb_sticky, rb_sticky;
    logic                 pp_sticky;
    logic [MAX_BALLS-1:0] rb_low;
    logic [NUM_BALLS-1:0] rb_first;
    logic                 tick, suppress;

    assign pb_now = {NUM_BALLS{playerDR}} & ballDR;
    assign rb_now = {NUM_BALLS{ropeDR & ropeActive}} & ballDR;
    assign pp_now = playerDR & presentDR;
    assign tick   = startOfFrame & enable;

    // The rope is consumed by its first hit: keep the lowest ball only.
    assign rb_low   = lowest_onehot(MAX_BALLS'(rb_sticky));
    assign rb_first = rb_low[NUM_BALLS-1:0];

    // Sticky overlap flags; a strobe-cycle overlap seeds the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            pb_sticky <= '0;
            rb_sticky <= '0;
            pp_sticky <= 1'b0;
        end else if (startOfFrame) begin
            pb_sticky <= enable ? pb_now : '0;
            rb_sticky <= enable ? rb_now : '0;
            pp_sticky <= enable & pp_now;
        end else if (enable) begin
            pb_sticky <= pb_sticky | pb_now;
            rb_sticky <= rb_sticky | rb_now;
            pp_sticky <= pp_sticky | pp_now;
        end
    end

    // Publish registers: high for exactly one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_player_ball <= '0;
            col_rope_ball   <= '0;
            col_present     <= 1'b0;
        end else begin
            col_player_ball <= (tick && !suppress) ? pb_sticky : '0;
            col_rope_ball   <= tick ? rb_first : '0;
            col_present     <= tick & pp_sticky;
        end
    end

    invul_timer #(
        .INVUL_FRAMES (INVUL_FRAMES),
        .INVUL_W      (INVUL_W)
    ) u_invul_timer (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .hit          (|pb_sticky),
        .invulnerable (invulnerable),
        .suppress     (suppress)
    );

    a_balls_fit: assert property (
        @(posedge clk) NUM_BALLS <= MAX_BALLS
    ) else $error("NUM_BALLS exceeds MAX_BALLS");

    a_rope_onehot0: assert property (
        @(posedge clk) $onehot0(col_rope_ball)
    ) else $error("col_rope_ball not onehot0");

endmodule

// File: tb/tb_collision_event_generator.sv
// Randomized and directed bench for collision_event_generator.
// Reference model tracks frames and remaining invulnerable frames.
module tb_collision_event_generator;

    localparam int NB  = 4;
    localparam int INV = 60;

    logic          clk = 1'b0;
    logic          rst, sof, en, pdr, rdr, ract, prdr;
    logic [NB-1:0] bdr;
    logic [NB-1:0] col_pb, col_rb;
    logic          col_pp, invul;

    int n_vec = 0;
    int n_err = 0;
    int n_cyc = 0;

    logic [NB-1:0] m_pb, m_rb;
    logic          m_pp;
    int            left;
    logic [NB-1:0] e_pb, e_rb;
    logic          e_pp, e_inv;

    always #5 clk = ~clk;

    collision_event_generator #(
        .NUM_BALLS    (NB),
        .INVUL_FRAMES (INV),
        .INVUL_W      (6)
    ) dut (
        .clk             (clk),
        .reset           (rst),
        .startOfFrame    (sof),
        .enable          (en),
        .playerDR        (pdr),
        .ropeDR          (rdr),
        .ropeActive      (ract),
        .presentDR       (prdr),
        .ballDR          (bdr),
        .col_player_ball (col_pb),
        .col_rope_ball   (col_rb),
        .col_present     (col_pp),
        .invulnerable    (invul)
    );

    // Frame-level reference: what each strobe must report.
    task automatic model_step();
        logic [NB-1:0] pbn, rbn;
        logic          ppn;
        pbn  = pdr ? bdr : '0;
        rbn  = (rdr && ract) ? bdr : '0;
        ppn  = pdr && prdr;
        e_pb = '0;
        e_rb = '0;
        e_pp = 1'b0;
        if (rst) begin
            m_pb = '0;
            m_rb = '0;
            m_pp = 1'b0;
            left = 0;
        end else if (sof) begin
            if (en) begin
                if (left > 0) begin
                    left = left - 1;
                end else if (m_pb != 0) begin
                    e_pb = m_pb;
                    left = INV;
                end
                for (int i = 0; i < NB; i++)
                    if (m_rb[i] && e_rb == 0) e_rb[i] = 1'b1;
                e_pp = m_pp;
                m_pb = pbn;
                m_rb = rbn;
                m_pp = ppn;
            end else begin
                m_pb = '0;
                m_rb = '0;
                m_pp = 1'b0;
            end
        end else if (en) begin
            m_pb = m_pb | pbn;
            m_rb = m_rb | rbn;
            m_pp = m_pp | ppn;
        end
        e_inv = (left > 0);
    endtask

    task automatic chk(input string nm,
                       input logic [NB-1:0] got,
                       input logic [NB-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b exp=%b",
                     nm, n_cyc, got, exp);
        end
    endtask

    // One clock: model update at the edge, compare 1ns later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        n_cyc++;
        chk("col_player_ball", col_pb, e_pb);
        chk("col_rope_ball", col_rb, e_rb);
        chk("col_present", {3'b0, col_pp}, {3'b0, e_pp});
        chk("invulnerable", {3'b0, invul}, {3'b0, e_inv});
    endtask

    task automatic drv(input logic r, s, e, p, rd, ra, pr,
                       input logic [NB-1:0] b);
        rst  = r;
        sof  = s;
        en   = e;
        pdr  = p;
        rdr  = rd;
        ract = ra;
        prdr = pr;
        bdr  = b;
    endtask

    task automatic idle(input int n);
        drv(0, 0, 1, 0, 0, 0, 0, 4'b0);
        repeat (n) cyc();
    endtask

    task automatic strobe(input logic e);
        drv(0, 1, e, 0, 0, 0, 0, 4'b0);
        cyc();
        drv(0, 0, 1, 0, 0, 0, 0, 4'b0);
    endtask

    task automatic do_reset();
        drv(1, 0, 1, 0, 0, 0, 0, 4'b0);
        repeat (2) cyc();
        drv(0, 0, 1, 0, 0, 0, 0, 4'b0);
    endtask

    task automatic hit(input logic [NB-1:0] b);
        drv(0, 0, 1, 1, 0, 0, 0, b);
        cyc();
        drv(0, 0, 1, 0, 0, 0, 0, 4'b0);
    endtask

    initial begin
        drv(1, 0, 1, 0, 0, 0, 0, 4'b0);
        m_pb = '0; m_rb = '0; m_pp = 1'b0; left = 0;

        // Reset state
        repeat (3) cyc();
        chk("reset_pb", col_pb, 4'b0000);
        chk("reset_inv", {3'b0, invul}, 4'b0000);

        // Player on ball 2 for three pixels
        idle(3);
        drv(0, 0, 1, 1, 0, 0, 0, 4'b0100);
        repeat (3) cyc();
        idle(2);
        strobe(1);
        chk("pb_pulse", col_pb, 4'b0100);
        chk("inv_after_hit", {3'b0, invul}, 4'b0001);
        idle(1);
        chk("pb_one_cycle", col_pb, 4'b0000);

        // Rope on balls 1 and 3: lowest wins
        drv(0, 0, 1, 0, 1, 1, 0, 4'b1010);
        cyc();
        idle(1);
        strobe(1);
        chk("rope_prio", col_rb, 4'b0010);
        drv(0, 0, 1, 0, 1, 0, 0, 4'b1010);
        cyc();
        idle(1);
        strobe(1);
        chk("rope_inactive", col_rb, 4'b0000);

        // Invulnerability window
        do_reset();
        hit(4'b0001);
        strobe(1);
        chk("inv_first", col_pb, 4'b0001);
        for (int k = 1; k <= INV; k++) begin
            hit(4'b0001);
            idle(1);
            strobe(1);
            chk("inv_supp", col_pb, 4'b0000);
            chk("inv_level", {3'b0, invul},
                {3'b0, (k < INV) ? 1'b1 : 1'b0});
        end
        hit(4'b0001);
        strobe(1);
        chk("inv_rearm", col_pb, 4'b0001);

        // Overlap in the strobe cycle lands in the next frame
        do_reset();
        idle(2);
        drv(0, 1, 1, 1, 0, 0, 1, 4'b0);
        cyc();
        chk("same_cyc_now", {3'b0, col_pp}, 4'b0000);
        idle(3);
        strobe(1);
        chk("same_cyc_next", {3'b0, col_pp}, 4'b0001);

        // Reset mid-frame discards flags
        drv(0, 0, 1, 1, 0, 0, 1, 4'b0);
        cyc();
        do_reset();
        strobe(1);
        chk("rst_mid_pp", {3'b0, col_pp}, 4'b0000);
        chk("rst_mid_pb", col_pb, 4'b0000);

        // Disabled frames hold the counter
        hit(4'b1000);
        strobe(1);
        idle(2); strobe(1);
        idle(2); strobe(1);
        for (int k = 0; k < 5; k++) begin
            drv(0, 0, 0, 1, 1, 1, 1, 4'b1111);
            repeat (3) cyc();
            drv(0, 1, 0, 1, 1, 1, 1, 4'b1111);
            cyc();
            chk("dis_pb", col_pb, 4'b0000);
            chk("dis_rb", col_rb, 4'b0000);
            chk("dis_pp", {3'b0, col_pp}, 4'b0000);
            chk("dis_inv", {3'b0, invul}, 4'b0001);
        end
        for (int k = 0; k < INV - 3; k++) begin
            idle(1);
            strobe(1);
        end
        chk("hold_inv_57", {3'b0, invul}, 4'b0001);
        idle(1);
        strobe(1);
        chk("hold_inv_58", {3'b0, invul}, 4'b0000);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 6000; k++) begin
            drv(($urandom_range(0, 399) == 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 0),
                ($urandom_range(0, 5) == 0),
                NB'($urandom_range(0, 15) & $urandom_range(0, 15)));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/collision_event_generator.md
Name: collision_event_generator

Overview:
- Producer side of the collision interface: builds the per-frame collision flags that the collision detector consumes (player-ball, rope-ball, player-present).
- Watches per-pixel drawing requests from the object drawers during VGA scan and latches overlaps in sticky flags through the frame.
- At each startOfFrame it publishes the flags as single-cycle pulses, applies rope-hit priority and player invulnerability, then clears the flags.

Parameters:
- NUM_BALLS, 4, number of ball drawers; one ballDR bit per ball.
- INVUL_FRAMES, 60, number of frames that player-ball reports are suppressed after a reported player-ball hit.
- INVUL_W, 6, counter width; must satisfy 2^INVUL_W > INVUL_FRAMES.

Ports:
- clk  in  1  system clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle strobe at frame boundary.
- enable  in  1  game running; 0 freezes detection.
- playerDR  in  1  player drawing request, current pixel.
- ropeDR  in  1  rope drawing request.
- ropeActive  in  1  rope currently shot; rope overlaps ignored when 0.
- presentDR  in  1  present drawing request.
- ballDR  in  NUM_BALLS  per-ball drawing requests.
- col_player_ball  out  NUM_BALLS  one-cycle pulse per ball hit by player.
- col_rope_ball  out  NUM_BALLS  one-cycle pulse, at most one bit set (onehot0).
- col_present  out  1  one-cycle pulse, player touched present.
- invulnerable  out  1  level, high while player-ball reports are suppressed.

Behaviour:
- Reset (sync, high): all sticky flags, all outputs, invul counter = 0, FSM = ARMED. Reset mid-frame discards accumulated flags. No pulse is emitted on the first startOfFrame after reset unless an overlap occurred after reset.
- Accumulation, every cycle with enable=1 and startOfFrame=0:
  - pb_sticky[i] |= playerDR & ballDR[i]
  - rb_sticky[i] |= ropeDR & ropeActive & ballDR[i]
  - pp_sticky |= playerDR & presentDR
- Publish: on the cycle startOfFrame=1 is sampled, the registered outputs load from the sticky flags. Outputs are high for exactly the next cycle (latency 1) and 0 otherwise.
- Sticky clear on the startOfFrame cycle: an overlap in that same cycle goes into the new frame's flags, not the published ones.
- Rope priority: col_rope_ball = lowest-index set bit of rb_sticky only; higher-index bits are dropped, because the rope is consumed by its first hit.
- enable=0: no accumulation; publish still occurs but emits zeros; sticky flags are cleared at startOfFrame. The invul counter holds its value.
- Invulnerability FSM, advancing only on startOfFrame with enable=1:
  - ARMED: col_player_ball = pb_sticky. If pb_sticky != 0, load counter = INVUL_FRAMES and go to INVUL.
  - INVUL: col_player_ball forced to 0 and pb_sticky discarded. Counter decrements by 1 per frame. At counter==1 the next frame goes to ARMED (counter 0).
  - invulnerable = (state==INVUL).
  - INVUL_FRAMES=0 is illegal; an assertion flags it.
- col_present and col_rope_ball are not affected by invulnerability.
- Arithmetic: the counter is unsigned INVUL_W bits and saturates at 0, so it never wraps.
- Simultaneous events: player-ball, rope-ball and present may all pulse in the same cycle.

Decomposition:
- Package collision_pkg holds:
  - typedef enum logic {ARMED, INVUL} invul_state_t;
  - localparam NUM_BALLS_DEF=4 and INVUL_FRAMES_DEF=60;
  - function lowest_onehot(vector) returning the onehot0 lowest set bit.
- One sub-module, invul_timer: FSM plus counter, with inputs tick and hit, outputs invulnerable and suppress. The top holds the sticky flags and publish registers.

Test Plan:
- Overlap playerDR & ballDR[2] for 3 pixels mid-frame, then startOfFrame -> col_player_ball=4'b0100 for exactly 1 cycle, one cycle after the strobe; invulnerable=1 next.
- Rope overlap on balls 1 and 3 in the same frame, ropeActive=1 -> col_rope_ball=4'b0010 only. Same stimulus with ropeActive=0 -> 4'b0000.
- Player-ball hit, then another hit in each of the next INVUL_FRAMES=60 frames -> only the first pulses. A hit in frame 62 pulses again; invulnerable falls after the 60th subsequent strobe.
- Overlap in the same cycle as startOfFrame -> not in this publish; appears at the following startOfFrame.
- Accumulate a present hit, assert reset mid-frame, then startOfFrame -> col_present=0 and all outputs 0.
- enable=0 with overlaps on all objects, then startOfFrame -> all outputs 0; the invul counter value holds across the disabled frames.
